// File: rtl/fsm_gpl_status_pkg.sv
// Shared types and defaults for the gpl_status qualifying FSM.
package fsm_gpl_status_pkg;

  // Filter states; specreg is high exactly in ACTIVE and RELEASE.
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    CONFIRM = 2'b01,
    ACTIVE  = 2'b10,
    RELEASE = 2'b11
  } gpl_state_t;

  localparam int GPL_ON_CYCLES_DEF  = 4;
  localparam int GPL_OFF_CYCLES_DEF = 4;

  // Larger of two thresholds; sizes the shared run counter.
  function automatic int gpl_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fsm_gpl_status.sv
// Glitch filter with hysteresis on gpl_status: specreg rises after ON_CYCLES
// consecutive enabled high samples and falls after OFF_CYCLES consecutive
// enabled low samples. Disabled cycles freeze everything, including the run.
module fsm_gpl_status
  import fsm_gpl_status_pkg::*;
#(
  parameter int ON_CYCLES  = GPL_ON_CYCLES_DEF,
  parameter int OFF_CYCLES = GPL_OFF_CYCLES_DEF
) (
  input  logic clk,
  input  logic arst,
  input  logic gpl_status,
  input  logic ena,
  output logic specreg
);

  localparam int CNT_MAX = gpl_max(ON_CYCLES, OFF_CYCLES);
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] ON_CNT  = CW'(ON_CYCLES);
  localparam logic [CW-1:0] OFF_CNT = CW'(OFF_CYCLES);

  gpl_state_t    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_specreg;

  gpl_state_t    w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_spec_nxt;
  logic [CW-1:0] w_cnt_inc;

  // The counter only increments while strictly below its threshold, so the
  // increment can never wrap.
  assign w_cnt_inc = r_cnt + CW'(1);

  // Next-state, run counter and output decode; ena=0 leaves all three held.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_spec_nxt  = r_specreg;
    case (r_state)
      IDLE: begin
        w_spec_nxt = 1'b0;
        if (ena && gpl_status) begin
          if (ON_CYCLES == 1) begin
            w_state_nxt = ACTIVE;
            w_cnt_nxt   = '0;
            w_spec_nxt  = 1'b1;
          end else begin
            w_state_nxt = CONFIRM;
            w_cnt_nxt   = CW'(1);
          end
        end
      end
      CONFIRM: begin
        if (ena) begin
          if (gpl_status) begin
            if (w_cnt_inc == ON_CNT) begin
              w_state_nxt = ACTIVE;
              w_cnt_nxt   = '0;
              w_spec_nxt  = 1'b1;
            end else begin
              w_cnt_nxt   = w_cnt_inc;
            end
          end else begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end
        end
      end
      ACTIVE: begin
        w_spec_nxt = 1'b1;
        if (ena && !gpl_status) begin
          if (OFF_CYCLES == 1) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
            w_spec_nxt  = 1'b0;
          end else begin
            w_state_nxt = RELEASE;
            w_cnt_nxt   = CW'(1);
          end
        end
      end
      RELEASE: begin
        if (ena) begin
          if (!gpl_status) begin
            if (w_cnt_inc == OFF_CNT) begin
              w_state_nxt = IDLE;
              w_cnt_nxt   = '0;
              w_spec_nxt  = 1'b0;
            end else begin
              w_cnt_nxt   = w_cnt_inc;
            end
          end else begin
            // A high sample aborts the release; specreg never dropped.
            w_state_nxt = ACTIVE;
            w_cnt_nxt   = '0;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
        w_spec_nxt  = 1'b0;
      end
    endcase
  end

  // State, counter and output registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (arst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_specreg <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_specreg <= w_spec_nxt;
    end
  end

  assign specreg = r_specreg;

endmodule

// File: tb/tb_fsm_gpl_status.sv
// Directed vector bench for fsm_gpl_status with default thresholds (4/4).
module tb_fsm_gpl_status;
  import fsm_gpl_status_pkg::*;

  logic clk;
  logic arst;
  logic gpl_status;
  logic ena;
  logic specreg;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       arst;
    logic       ena;
    logic       gpl;
    logic       exp_spec;
    gpl_state_t exp_st;
  } vec_t;

  vec_t vq[$];

  fsm_gpl_status dut (
    .clk       (clk),
    .arst      (arst),
    .gpl_status(gpl_status),
    .ena       (ena),
    .specreg   (specreg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic a, input logic e, input logic g,
                     input logic s, input gpl_state_t st);
    vec_t v;
    v.arst = a; v.ena = e; v.gpl = g; v.exp_spec = s; v.exp_st = st;
    vq.push_back(v);
  endtask

  // Drive at the falling edge, sample 1 ns after the rising edge.
  task automatic step(input logic a, input logic e, input logic g);
    @(negedge clk);
    arst = a; ena = e; gpl_status = g;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic exp_spec, input gpl_state_t exp_st);
    total++;
    if (specreg !== exp_spec || dut.r_state !== exp_st) begin
      bad++;
      $display("FAIL %s: specreg=%b state=%s, want specreg=%b state=%s",
               name, specreg, dut.r_state.name(), exp_spec, exp_st.name());
    end
  endtask

  initial begin
    arst = 1'b1; ena = 1'b0; gpl_status = 1'b0;

    // Reset held 4 cycles.
    repeat (4) add(1, 0, 0, 0, IDLE);
    // Assert: 17 high samples; rises after the 4th.
    repeat (3) add(0, 1, 1, 0, CONFIRM);
    repeat (14) add(0, 1, 1, 1, ACTIVE);
    // Deassert: falls after the 4th low sample.
    repeat (3) add(0, 1, 0, 1, RELEASE);
    add(0, 1, 0, 0, IDLE);
    add(0, 1, 0, 0, IDLE);
    // 3-cycle high glitch: one short, no change.
    repeat (3) add(0, 1, 1, 0, CONFIRM);
    add(0, 1, 0, 0, IDLE);
    // Re-enter ACTIVE, then 3-cycle low glitch.
    repeat (3) add(0, 1, 1, 0, CONFIRM);
    add(0, 1, 1, 1, ACTIVE);
    repeat (3) add(0, 1, 0, 1, RELEASE);
    add(0, 1, 1, 1, ACTIVE);
    // ena=0 in ACTIVE with low input holds.
    repeat (2) add(0, 0, 0, 1, ACTIVE);
    // Back to IDLE.
    repeat (3) add(0, 1, 0, 1, RELEASE);
    add(0, 1, 0, 0, IDLE);
    // Enable freeze: 2 samples, 5 frozen cycles, 2 more samples.
    repeat (2) add(0, 1, 1, 0, CONFIRM);
    add(0, 0, 0, 0, CONFIRM);
    add(0, 0, 1, 0, CONFIRM);
    add(0, 0, 0, 0, CONFIRM);
    add(0, 0, 1, 0, CONFIRM);
    add(0, 0, 0, 0, CONFIRM);
    add(0, 1, 1, 0, CONFIRM);
    add(0, 1, 1, 1, ACTIVE);
    // Reset mid-ACTIVE with input high: reset wins, full run needed again.
    add(1, 1, 1, 0, IDLE);
    repeat (3) add(0, 1, 1, 0, CONFIRM);
    add(0, 1, 1, 1, ACTIVE);

    foreach (vq[i]) begin
      step(vq[i].arst, vq[i].ena, vq[i].gpl);
      check($sformatf("vec%0d", i), vq[i].exp_spec, vq[i].exp_st);
    end

    // Hand sequence: freeze inside RELEASE must not break the low run.
    step(0, 1, 0); check("rel_frz_s1", 1'b1, RELEASE);
    step(0, 1, 0); check("rel_frz_s2", 1'b1, RELEASE);
    repeat (3) begin
      step(0, 0, 1); check("rel_frz_hold", 1'b1, RELEASE);
    end
    step(0, 1, 0); check("rel_frz_s3", 1'b1, RELEASE);
    step(0, 1, 0); check("rel_frz_s4", 1'b0, IDLE);

    // Hand sequence: low sample in CONFIRM restarts the run from scratch.
    step(0, 1, 1); step(0, 1, 1); step(0, 1, 1);
    step(0, 1, 0); check("confirm_abort", 1'b0, IDLE);
    step(0, 1, 1); step(0, 1, 1); step(0, 1, 1);
    check("confirm_restart_short", 1'b0, CONFIRM);
    step(0, 1, 1); check("confirm_restart_full", 1'b1, ACTIVE);

    // Hand sequence: reset during RELEASE clears immediately.
    step(0, 1, 0); step(0, 1, 0);
    step(1, 1, 0); check("rst_in_release", 1'b0, IDLE);
    step(0, 1, 0); check("idle_after_rst", 1'b0, IDLE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
